// File: rtl/wr_full_ctrl_if.sv
// Write-side status bus between the write-pointer counter/producer and wr_full_ctrl.
// Winc is a write request and W_en is its acceptance: a write happens on an edge only when both are high.
interface wr_full_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  Winc;
    logic [ADDR_WIDTH:0]   write_addr;
    logic [ADDR_WIDTH:0]   rd_ptr_gray;
    logic                  W_en;
    logic                  FULL_flag;
    logic                  ALMOST_FULL;
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic [ADDR_WIDTH:0]   wr_level;

    modport master (
        output Winc, write_addr, rd_ptr_gray,
        input  W_en, FULL_flag, ALMOST_FULL, wr_ptr_gray, wr_level
    );

    modport slave (
        input  Winc, write_addr, rd_ptr_gray,
        output W_en, FULL_flag, ALMOST_FULL, wr_ptr_gray, wr_level
    );
endinterface

// File: rtl/wr_full_ctrl.sv
// Write-domain status for the async FIFO: synchronises the read Gray pointer into W_CLK
// and produces registered full/almost-full, the Gray write pointer and the write-side fill level.
module wr_full_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic              W_CLK,
    input  logic              RST,
    wr_full_ctrl_if.slave     bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = AFULL_THRESH[PW-1:0];

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq_sync;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain, nothing combinational between stages.
    always_ff @(posedge W_CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_sync = sync_q[SYNC_STAGES-1];
    assign rd_bin  = gray2bin(rq_sync);

    assign bus.W_en = bus.Winc & ~bus.FULL_flag;

    // Mirrors the counter's own increment so registered outputs line up with write_addr.
    assign wptr_next  = bus.write_addr + {{ADDR_WIDTH{1'b0}}, bus.W_en};
    assign wgray_next = wptr_next ^ (wptr_next >> 1);
    assign full_cmp   = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    assign level_next = wptr_next - rd_bin;

    always_ff @(posedge W_CLK or negedge RST) begin
        if (!RST) begin
            bus.FULL_flag   <= 1'b0;
            bus.ALMOST_FULL <= 1'b0;
            bus.wr_ptr_gray <= '0;
            bus.wr_level    <= '0;
        end else begin
            bus.FULL_flag   <= (wgray_next == full_cmp);
            bus.ALMOST_FULL <= (level_next >= AFULL_LVL);
            bus.wr_ptr_gray <= wgray_next;
            bus.wr_level    <= level_next;
        end
    end
endmodule

// File: tb/tb_wr_full_ctrl.sv
// Directed bench for wr_full_ctrl: drivers push expected state vectors, a monitor pops and compares.
module tb_wr_full_ctrl;
    localparam int W = 15;

    logic W_CLK = 1'b0;
    logic RST   = 1'b0;
    logic chk_now = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    int           exp_tag[$];
    string        exp_name[$];

    wr_full_ctrl_if #(.ADDR_WIDTH(3)) bus ();

    wr_full_ctrl #(
        .ADDR_WIDTH(3),
        .SYNC_STAGES(2),
        .AFULL_THRESH(6)
    ) dut (
        .W_CLK(W_CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 W_CLK = ~W_CLK;

    always @(posedge W_CLK) cyc <= cyc + 1;

    // Stand-in for the write-pointer counter that sits beside the block.
    always @(posedge W_CLK or negedge RST) begin
        if (!RST) bus.write_addr <= '0;
        else if (bus.W_en) bus.write_addr <= bus.write_addr + 4'd1;
    end

    function automatic logic [W-1:0] pk(input logic [3:0] wa, input logic f, input logic af,
                                        input logic we, input logic [3:0] g, input logic [3:0] l);
        return {wa, f, af, we, g, l};
    endfunction

    // Monitor: negedge checks for clocked state, chk_now for asynchronous reset checks.
    always @(negedge W_CLK or posedge chk_now) begin
        while (exp_q.size() > 0 && ((exp_tag[0] < 0) ? chk_now : (exp_tag[0] <= cyc))) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string nm;
            e  = exp_q.pop_front();
            nm = exp_name.pop_front();
            void'(exp_tag.pop_front());
            a  = {bus.write_addr, bus.FULL_flag, bus.ALMOST_FULL, bus.W_en, bus.wr_ptr_gray, bus.wr_level};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got wa=%0d full=%b afull=%b w_en=%b gray=%b level=%0d, expected wa=%0d full=%b afull=%b w_en=%b gray=%b level=%0d",
                         nm, a[14:11], a[10], a[9], a[8], a[7:4], a[3:0],
                         e[14:11], e[10], e[9], e[8], e[7:4], e[3:0]);
            end
        end
    end

    task automatic tick();
        @(posedge W_CLK);
        #1;
    endtask

    task automatic step(input logic [W-1:0] e, input string nm);
        exp_q.push_back(e);
        exp_tag.push_back(cyc);
        exp_name.push_back(nm);
        tick();
    endtask

    // Drops RST between edges, checks the cleared outputs at once, then releases after an edge.
    task automatic async_reset(input logic [W-1:0] e, input string nm,
                               input logic winc_rel, input logic [3:0] rd_rel);
        @(posedge W_CLK);
        #3;
        RST = 1'b0;
        #1;
        exp_q.push_back(e);
        exp_tag.push_back(-1);
        exp_name.push_back(nm);
        chk_now = 1'b1;
        #0.5;
        chk_now = 1'b0;
        @(posedge W_CLK);
        #1;
        bus.Winc        = winc_rel;
        bus.rd_ptr_gray = rd_rel;
        RST = 1'b1;
    endtask

    initial begin
        bus.Winc        = 1'b1;
        bus.rd_ptr_gray = 4'b0101;

        // Reset held with Winc high and a non-zero read pointer on the input.
        tick();
        step(pk(4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd0), "in_reset");
        bus.rd_ptr_gray = 4'b0000;
        bus.Winc        = 1'b0;
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) step(pk(4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0), "idle_after_reset");

        // Fill from empty.
        bus.Winc = 1'b1;
        step(pk(4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd0), "fill_0");
        step(pk(4'd1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd1), "fill_1");
        step(pk(4'd2, 1'b0, 1'b0, 1'b1, 4'b0011, 4'd2), "fill_2");
        step(pk(4'd3, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd3), "fill_3");
        step(pk(4'd4, 1'b0, 1'b0, 1'b1, 4'b0110, 4'd4), "fill_4");
        step(pk(4'd5, 1'b0, 1'b0, 1'b1, 4'b0111, 4'd5), "fill_5");
        step(pk(4'd6, 1'b0, 1'b1, 1'b1, 4'b0101, 4'd6), "fill_6_afull");
        step(pk(4'd7, 1'b0, 1'b1, 1'b1, 4'b0100, 4'd7), "fill_7");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "fill_8_full");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "full_hold");

        // One read while full: visible on the third edge.
        bus.rd_ptr_gray = 4'b0001;
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "drain_e0");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "drain_e1");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "drain_e2");
        step(pk(4'd8, 1'b0, 1'b1, 1'b1, 4'b1100, 4'd7), "drain_e3");
        step(pk(4'd9, 1'b1, 1'b1, 1'b0, 4'b1101, 4'd8), "refill_9");

        // Wrap: fill to 8, read pointer jumps to 8, fill 8 more.
        async_reset(pk(4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd0), "reset_from_full", 1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) tick();
        bus.rd_ptr_gray = 4'b1100;
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "wrap_full_e0");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "wrap_full_e1");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "wrap_full_e2");
        step(pk(4'd8, 1'b0, 1'b0, 1'b1, 4'b1100, 4'd0), "wrap_empty_e3");
        for (int i = 0; i < 4; i++) tick();
        step(pk(4'd13, 1'b0, 1'b0, 1'b1, 4'b1011, 4'd5), "wrap_13");
        step(pk(4'd14, 1'b0, 1'b1, 1'b1, 4'b1001, 4'd6), "wrap_14_afull");
        tick();
        step(pk(4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'd8), "wrap_full_0");
        step(pk(4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'd8), "wrap_full_hold");

        // Read advances on the same edge as the filling write.
        async_reset(pk(4'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'd0), "reset_from_wrap", 1'b1, 4'b0000);
        for (int i = 0; i < 7; i++) tick();
        bus.rd_ptr_gray = 4'b0001;
        step(pk(4'd7, 1'b0, 1'b1, 1'b1, 4'b0100, 4'd7), "simul_7");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "simul_full_e1");
        step(pk(4'd8, 1'b1, 1'b1, 1'b0, 4'b1100, 4'd8), "simul_full_e2");
        step(pk(4'd8, 1'b0, 1'b1, 1'b1, 4'b1100, 4'd7), "simul_clear_e3");
        bus.Winc = 1'b0;

        // Mid-operation reset at write_addr = 5.
        async_reset(pk(4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0), "reset_after_simul", 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) tick();
        bus.Winc = 1'b0;
        step(pk(4'd5, 1'b0, 1'b0, 1'b0, 4'b0111, 4'd5), "mid_at_5");
        async_reset(pk(4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0), "mid_reset", 1'b0, 4'b0000);
        step(pk(4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0), "after_mid_reset");

        tick();
        tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wr_full_ctrl.md
Name: wr_full_ctrl

Overview:
Write-domain status controller for the asynchronous FIFO.
- Sits beside the write-pointer counter in the W_CLK domain.
- Synchronises the read side's Gray-coded pointer into W_CLK and generates the registered FULL_flag and ALMOST_FULL that throttle the write pointer.
- Publishes the Gray-coded write pointer and the write-side fill level for the read domain and for debug.

Parameters:
ADDR_WIDTH, 3, memory address bits; pointers are ADDR_WIDTH+1 bits wide; depth = 2**ADDR_WIDTH (8).
SYNC_STAGES, 2, flops in the read-pointer synchroniser chain; minimum 2.
AFULL_THRESH, 6, fill level at or above which ALMOST_FULL asserts; range 1..2**ADDR_WIDTH.

Ports:
W_CLK  input  1  write-domain clock.
RST  input  1  asynchronous, active-low reset.
Winc  input  1  write request from the producer.
write_addr  input  ADDR_WIDTH+1  binary write pointer from the write-pointer counter; MSB is the wrap bit.
rd_ptr_gray  input  ADDR_WIDTH+1  Gray-coded read pointer, launched from the read clock domain; asynchronous to W_CLK.
W_en  output  1  memory write strobe = Winc & ~FULL_flag; combinational.
FULL_flag  output  1  registered full indication.
ALMOST_FULL  output  1  registered, level >= AFULL_THRESH.
wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer sent to the read domain.
wr_level  output  ADDR_WIDTH+1  registered entries in use as seen by the write side, 0..2**ADDR_WIDTH.

Behaviour:
- Reset (RST low, asynchronous): all synchroniser flops = 0; FULL_flag = 0, ALMOST_FULL = 0, wr_ptr_gray = 0, wr_level = 0.
- Reset release is synchronous to W_CLK at the counter level only. No extra reset synchroniser is included in this block.
- Synchroniser: rd_ptr_gray passes through SYNC_STAGES flops clocked by W_CLK; rq_sync is the last stage.
  - rd_bin = gray-to-binary(rq_sync).
  - No logic between stages.
- Next write pointer: wptr_next = write_addr + W_en, modulo 2**(ADDR_WIDTH+1).
  - This matches the counter's own update, so all registered outputs align with write_addr after the same edge.
- Registered outputs, every W_CLK edge:
  - wr_ptr_gray <= bin2gray(wptr_next), where bin2gray(b) = b ^ (b>>1).
  - FULL_flag <= (bin2gray(wptr_next) == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}). This is the Gray full test: top two bits differ, remaining bits equal.
  - wr_level <= wptr_next - rd_bin, modulo 2**(ADDR_WIDTH+1); never exceeds 2**ADDR_WIDTH.
  - ALMOST_FULL <= (wptr_next - rd_bin) >= AFULL_THRESH.
- Latency:
  - The write that fills the last entry asserts FULL_flag on the same edge at which write_addr takes its full value.
  - A change on rd_ptr_gray that is stable before an edge is reflected in FULL_flag/wr_level on the (SYNC_STAGES+1)-th W_CLK edge.
- Boundaries:
  - FULL_flag high: W_en = 0 regardless of Winc, so write_addr holds and no overwrite occurs.
  - Winc high on the edge that reaches full: the write is accepted, and FULL_flag rises on that same edge.
  - Read pointer advances in the same cycle as the filling write: FULL_flag may assert and then deassert after the synchroniser delay. This is pessimistic and allowed; FULL_flag must never be low while the FIFO is truly full.
  - Wrap-around: pointer arithmetic is modulo 2**(ADDR_WIDTH+1), and full/level stay correct across any number of wraps.
  - Reset mid-operation: outputs clear immediately. The read domain must be reset concurrently; this block does not detect mismatched resets.
- rd_ptr_gray is assumed to change by at most one bit per read-clock edge, which is guaranteed by the Gray encoding at the source.

Test Plan:
- Reset with RST=0 while Winc=1 and rd_ptr_gray=4'b0101 -> all outputs 0 and W_en=1; after release and 3 idle edges, wr_level=6 is not required (write_addr=0, rd_bin=6 is illegal). Bench holds rd_ptr_gray=0.
- Fill from empty (rd_ptr_gray=0, Winc=1 for 10 edges) -> ALMOST_FULL rises with write_addr=6; FULL_flag rises with write_addr=8, wr_ptr_gray=4'b1100, wr_level=8; W_en=0 thereafter and write_addr stays 8.
- Drain one while full (rd_ptr_gray=4'b0001) -> FULL_flag falls on the 3rd edge, wr_level=7, ALMOST_FULL stays 1, W_en returns to 1.
- Wrap (write 8, set rd_ptr_gray=4'b1100 i.e. rd=8, write 8 more) -> FULL_flag rises when write_addr=0, wr_ptr_gray=0, wr_level=8.
- Simultaneous: 8th write on the same edge that rd_ptr_gray goes 0->1 -> FULL_flag high for 2 edges, then low with wr_level=7; no extra write is accepted while high.
- Mid-operation reset at write_addr=5 -> FULL_flag, ALMOST_FULL, wr_ptr_gray and wr_level all 0 immediately, asynchronous to W_CLK.
